// File: rtl/word_ctl_pkg.sv
// Shared definitions for the word XOR arbiter.
//   - Word widths and the default mask value loaded at reset.
//   - rslt_state_t : state of the one-entry result register.
//   - word_op()    : the shared datapath function, {8'h00, d} ^ m.
package word_ctl_pkg;

    localparam int          WORD_IN_W        = 8;
    localparam int          WORD_OUT_W       = 16;
    localparam logic [15:0] MASK_RST_DEFAULT = 16'h0001;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rslt_state_t;

    // Zero-extend the input word, then XOR with the full 16-bit mask.
    // The upper byte of the result is therefore the mask's upper byte.
    function automatic logic [WORD_OUT_W-1:0] word_op(
        input logic [WORD_IN_W-1:0]  d,
        input logic [WORD_OUT_W-1:0] m
    );
        return {{(WORD_OUT_W-WORD_IN_W){1'b0}}, d} ^ m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req      in   NREQ  request vector
//   pointer  in   IDW   highest-priority position for this cycle
//   en       in   1     allow a grant this cycle
//   grant    out  NREQ  one-hot grant (all zero when en=0 or no request)
//   grant_idx out IDW   index of the granted requester
//   any      out  1     a grant was issued
// The pointer register itself lives in the parent.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  pointer,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   rot;
    logic [IDW-1:0]    offset;
    logic [IDW:0]      idx_sum;
    logic              found;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the block leaves a value held (no latch).
        req_dbl = '0;
        rot     = '0;
        offset  = '0;
        found   = 1'b0;
        idx_sum = '0;
        grant   = '0;

        // Rotate the request vector so that bit 0 is the pointer position;
        // doubling the vector makes the wrap-around free.
        req_dbl = {req, req} >> pointer;
        rot     = req_dbl[NREQ-1:0];

        for (int off = 0; off < NREQ; off++) begin
            if (!found && rot[off]) begin
                found  = 1'b1;
                offset = IDW'(off);
            end
        end

        // Map the rotated offset back to an absolute index, modulo NREQ.
        idx_sum = {1'b0, pointer} + {1'b0, offset};
        if (idx_sum >= (IDW+1)'(NREQ)) begin
            idx_sum = idx_sum - (IDW+1)'(NREQ);
        end

        any       = en && found;
        grant_idx = idx_sum[IDW-1:0];

        for (int i = 0; i < NREQ; i++) begin
            grant[i] = any && (grant_idx == IDW'(i));
        end
    end

endmodule

// File: rtl/word_xor_arbiter.sv
// Shares one resize/XOR datapath between NREQ requesters.
//   clk, rst       system clock; synchronous active-high reset
//   req_valid      per-requester valid
//   req_data       per-requester 8-bit word, requester i at [8*i+7:8*i]
//   req_ready      one-hot grant (combinational)
//   rsp_valid      result register holds a result
//   rsp_ready      downstream accepts the result
//   rsp_data       {8'h00, word} ^ mask
//   rsp_id         index of the requester that produced rsp_data
//   cfg_we         mask write strobe
//   cfg_mask       new mask value
//   op_count       number of accepted requests (wraps)
module word_xor_arbiter
    import word_ctl_pkg::*;
#(
    parameter int          NREQ     = 4,
    parameter int          IDW      = $clog2(NREQ),
    parameter logic [15:0] MASK_RST = MASK_RST_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*8-1:0]      req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WORD_OUT_W-1:0]  rsp_data,
    output logic [IDW-1:0]         rsp_id,
    input  logic                   cfg_we,
    input  logic [WORD_OUT_W-1:0]  cfg_mask,
    output logic [15:0]            op_count
);

    rslt_state_t           state, state_nxt;
    logic [IDW-1:0]        pointer;
    logic [WORD_OUT_W-1:0] mask;
    logic                  accept;
    logic                  grant_en;
    logic [NREQ-1:0]       grant;
    logic [IDW-1:0]        grant_idx;
    logic                  any;
    logic [WORD_IN_W-1:0]  sel_word;

    // The register can take a new result when empty, or when the held
    // result retires in this same edge (no bubble).
    assign accept   = (state == EMPTY) || rsp_ready;
    assign grant_en = accept && !rst;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req       (req_valid),
        .pointer   (pointer),
        .en        (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    assign req_ready = grant;

    // Select the granted word with a one-hot mux so the grant logic never
    // looks at req_data.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_word = req_data[i*8 +: 8];
            end
        end
    end

    // Result-register FSM: next state and outputs.
    always_comb begin
        state_nxt = state;
        rsp_valid = (state == FULL);
        if (any) begin
            state_nxt = FULL;
        end else if ((state == FULL) && rsp_ready) begin
            state_nxt = EMPTY;
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so every
    // register samples values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers. The grant in this cycle reads the current mask,
    // so a same-cycle mask write only affects later grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_id   <= '0;
            op_count <= '0;
            mask     <= MASK_RST;
            pointer  <= '0;
        end else begin
            if (cfg_we) begin
                mask <= cfg_mask;
            end
            if (any) begin
                rsp_data <= word_op(sel_word, mask);
                rsp_id   <= grant_idx;
                op_count <= op_count + 16'd1;
                pointer  <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
            end
        end
    end

endmodule

// File: tb/tb_word_xor_arbiter.sv
module tb_word_xor_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        cfg_we;
    logic [15:0] cfg_mask;
    logic [15:0] op_count;

    int total = 0;
    int bad   = 0;

    word_xor_arbiter #(
        .NREQ     (4),
        .IDW      (2),
        .MASK_RST (16'h0001)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .cfg_we    (cfg_we),
        .cfg_mask  (cfg_mask),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; registered outputs are read 1ns
    // after the rising edge, combinational outputs 1ns after the falling edge.
    task automatic apply_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_mask  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'hF;
        req_data  = 32'h44332211;
        rsp_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_mask  = '0;
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL reset_req_ready got=%b exp=%b", req_ready, 4'b0000);
        end
        @(posedge clk); @(posedge clk); #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid);
        end
        total++;
        if (rsp_data !== 16'h0000) begin
            bad++; $display("FAIL reset_rsp_data got=%h exp=0000", rsp_data);
        end
        total++;
        if (rsp_id !== 2'd0) begin
            bad++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id);
        end
        total++;
        if (op_count !== 16'h0000) begin
            bad++; $display("FAIL reset_op_count got=%h exp=0000", op_count);
        end
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    // Single request after reset: 8'hFE ^ mask 16'h0001 = 16'h00FF.
    task automatic test_single();
        @(negedge clk);
        req_valid = 4'b0001;
        req_data  = 32'h000000FE;
        rsp_ready = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL single_grant got=%b exp=0001", req_ready);
        end
        @(posedge clk); #1;
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h00FF || rsp_id !== 2'd0) begin
            bad++; $display("FAIL single_result got=v%b d=%h id=%0d exp=v1 d=00ff id=0",
                            rsp_valid, rsp_data, rsp_id);
        end
        total++;
        if (op_count !== 16'd1) begin
            bad++; $display("FAIL single_op_count got=%0d exp=1", op_count);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    // All four valid, sink always ready: grants 0,1,2,3,0 back to back.
    task automatic test_round_robin();
        logic [3:0]  exp_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [15:0] exp_data [5] = '{16'h0011, 16'h0021, 16'h0031, 16'h0041, 16'h0011};
        logic [1:0]  exp_id   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset();
        req_valid = 4'hF;
        req_data  = 32'h40302010;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            total++;
            if (req_ready !== exp_gnt[i]) begin
                bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, req_ready, exp_gnt[i]);
            end
            @(posedge clk); #1;
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_data[i] || rsp_id !== exp_id[i]) begin
                bad++; $display("FAIL rr_result[%0d] got=v%b d=%h id=%0d exp=v1 d=%h id=%0d",
                                i, rsp_valid, rsp_data, rsp_id, exp_data[i], exp_id[i]);
            end
        end
        total++;
        if (op_count !== 16'd5) begin
            bad++; $display("FAIL rr_op_count got=%0d exp=5", op_count);
        end
    endtask

    // Held result 16'h0011 from requester 0, pointer at 1.
    task automatic test_backpressure();
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            total++;
            if (req_ready !== 4'b0000) begin
                bad++; $display("FAIL bp_req_ready[%0d] got=%b exp=0000", i, req_ready);
            end
            @(posedge clk); #1;
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'h0011 || rsp_id !== 2'd0
                || op_count !== 16'd5) begin
                bad++; $display("FAIL bp_hold[%0d] got=v%b d=%h id=%0d cnt=%0d exp=v1 d=0011 id=0 cnt=5",
                                i, rsp_valid, rsp_data, rsp_id, op_count);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++; $display("FAIL bp_resume_grant got=%b exp=0010", req_ready);
        end
        @(posedge clk); #1;
        total++;
        if (rsp_data !== 16'h0021 || rsp_id !== 2'd1 || op_count !== 16'd6) begin
            bad++; $display("FAIL bp_resume_result got=d%h id=%0d cnt=%0d exp=d0021 id=1 cnt=6",
                            rsp_data, rsp_id, op_count);
        end
        // Drain: no requests with sink ready returns to EMPTY.
        @(negedge clk);
        req_valid = '0;
        @(posedge clk); #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL bp_drain got=%b exp=0", rsp_valid);
        end
    endtask

    // Pointer at 2. Mask write coincides with a grant of 8'h0F.
    task automatic test_mask_write();
        @(negedge clk);
        req_valid = 4'b0100;
        req_data  = 32'h000F0000;
        rsp_ready = 1'b1;
        cfg_we    = 1'b1;
        cfg_mask  = 16'hA5A5;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL mask_grant got=%b exp=0100", req_ready);
        end
        @(posedge clk); #1;
        total++;
        if (rsp_data !== 16'h000E || rsp_id !== 2'd2) begin
            bad++; $display("FAIL mask_old got=d%h id=%0d exp=d000e id=2", rsp_data, rsp_id);
        end
        @(negedge clk);
        cfg_we = 1'b0;
        @(posedge clk); #1;
        total++;
        if (rsp_data !== 16'hA5AA || rsp_id !== 2'd2) begin
            bad++; $display("FAIL mask_new got=d%h id=%0d exp=da5aa id=2", rsp_data, rsp_id);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    // Counter wraps 16'hFFFF -> 16'h0000 after 65536 grants.
    task automatic test_wrap();
        apply_reset();
        req_valid = 4'b0001;
        req_data  = 32'h00000055;
        rsp_ready = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        total++;
        if (op_count !== 16'hFFFF) begin
            bad++; $display("FAIL wrap_preload got=%h exp=ffff", op_count);
        end
        @(posedge clk); #1;
        total++;
        if (op_count !== 16'h0000) begin
            bad++; $display("FAIL wrap_zero got=%h exp=0000", op_count);
        end
        total++;
        if (rsp_data !== 16'h0054) begin
            bad++; $display("FAIL wrap_data got=%h exp=0054", rsp_data);
        end
    endtask

    // Reset while a result is held, then requesters 3 and 0 together.
    task automatic test_reset_mid();
        @(negedge clk);
        rsp_ready = 1'b0;
        cfg_we    = 1'b1;
        cfg_mask  = 16'hFF00;
        @(negedge clk);
        cfg_we    = 1'b0;
        rst       = 1'b1;
        req_valid = 4'b1001;
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL rmid_req_ready got=%b exp=0000", req_ready);
        end
        @(posedge clk); #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rmid_valid got=%b exp=0", rsp_valid);
        end
        @(negedge clk);
        rst       = 1'b0;
        req_data  = 32'h44000033;
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL rmid_first_grant got=%b exp=0001", req_ready);
        end
        @(posedge clk); #1;
        total++;
        if (rsp_data !== 16'h0032 || rsp_id !== 2'd0 || op_count !== 16'd1) begin
            bad++; $display("FAIL rmid_result got=d%h id=%0d cnt=%0d exp=d0032 id=0 cnt=1",
                            rsp_data, rsp_id, op_count);
        end
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        total++;
        if (req_ready !== 4'b1000) begin
            bad++; $display("FAIL rmid_second_grant got=%b exp=1000", req_ready);
        end
        @(posedge clk); #1;
        total++;
        if (rsp_data !== 16'h0045 || rsp_id !== 2'd3) begin
            bad++; $display("FAIL rmid_second got=d%h id=%0d exp=d0045 id=3", rsp_data, rsp_id);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_mask  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_mask_write();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
